// File: rtl/riscv_pkg.sv
// Shared constants for the instruction fetch front end.
// Holds the instruction width, the sequential pc step, the encoding of the
// fetch queue's derived RUN/DRAIN state and the counter width helper.
package riscv_pkg;

    // Width of one instruction word returned by instruction memory.
    localparam int INST_W = 32;

    // Byte distance between two sequential instruction fetches.
    localparam int PC_STEP = 4;

    // Derived fetch state: RUN accepts every response, DRAIN drops stale ones.
    localparam logic [0:0] FQ_RUN   = 1'b0;
    localparam logic [0:0] FQ_DRAIN = 1'b1;

    // Occupancy counters must hold the value DEPTH itself, hence the extra bit.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO used to buffer fetched {instruction, pc} pairs.
// The head entry is presented combinationally; flush empties the queue in
// one cycle and takes priority over push and pop in the same cycle.
module sync_fifo
    import riscv_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int CNT_W = cnt_width(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    // Ignore a push into a full queue and a pop from an empty one so the
    // pointers and the count can never disagree.
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Occupancy only moves when exactly one of push/pop happens.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            count_q <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage needs no reset; validity is tracked by the count alone.
    always_ff @(posedge clock) begin
        if (do_push) begin
            storage[wr_ptr] <= push_data;
        end
    end

    assign pop_data = storage[rd_ptr];
    assign count    = count_q;
    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch queue sitting between the pc/branch logic and decode.
// Issues sequential word fetches over a ready/valid request channel, keeps
// in-order responses in a small FIFO and hands {inst, inst_pc} to decode.
// A redirect restarts fetch at the new target, flushes the FIFO and arranges
// for every response still in flight to be silently dropped.
module ifetch_queue
    import riscv_pkg::*;
#(
    parameter int              XLEN  = 32,
    parameter logic [XLEN-1:0] RESET = '0,
    parameter int              DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              redirect,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [XLEN-1:0]   mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [INST_W-1:0] mem_rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [XLEN-1:0]   inst_pc
);

    localparam int CNT_W   = cnt_width(DEPTH);
    localparam int ENTRY_W = INST_W + XLEN;

    logic [XLEN-1:0]    fetch_pc;
    logic [XLEN-1:0]    rsp_pc;
    logic [XLEN-1:0]    redirect_target;
    logic [CNT_W-1:0]   outstanding;
    logic [CNT_W-1:0]   discard;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_empty;
    logic               fifo_full;
    logic [ENTRY_W-1:0] fifo_head;
    logic [0:0]         state;
    logic               credit_ok;
    logic               req_fire;
    logic               rsp_push;
    logic               inst_pop;
    logic               unused_redirect_bits;

    // Redirect targets are always word aligned; the low bits are don't-care.
    assign redirect_target      = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_redirect_bits = ^redirect_pc[1:0];

    // A fetch may only be issued while every in-flight and buffered word is
    // guaranteed a FIFO slot, so a response can never find the FIFO full.
    assign credit_ok = ({1'b0, outstanding} + {1'b0, fifo_count}) < (CNT_W + 1)'(DEPTH);

    assign mem_req_valid = !reset && !redirect && credit_ok;
    assign mem_req_addr  = fetch_pc;
    assign req_fire      = mem_req_valid && mem_req_ready;

    // DRAIN simply means some responses in flight belong to an old path.
    assign state = (discard != '0) ? FQ_DRAIN : FQ_RUN;

    // Responses on a redirect cycle or while draining never reach the FIFO.
    assign rsp_push = mem_rsp_valid && !redirect && (state == FQ_RUN);

    // Decode cannot consume anything on a redirect cycle; the FIFO is flushed.
    assign inst_pop = inst_valid && inst_ready && !redirect;

    // Next address to request: restart on redirect, step on each handshake.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc <= RESET;
        end else if (redirect) begin
            fetch_pc <= redirect_target;
        end else if (req_fire) begin
            fetch_pc <= fetch_pc + XLEN'(PC_STEP);
        end
    end

    // Address of the next accepted response; it tracks fetch_pc one
    // response behind, so the pc is never carried through memory.
    always_ff @(posedge clock) begin
        if (reset) begin
            rsp_pc <= RESET;
        end else if (redirect) begin
            rsp_pc <= redirect_target;
        end else if (rsp_push) begin
            rsp_pc <= rsp_pc + XLEN'(PC_STEP);
        end
    end

    // Requests accepted by memory but not yet answered.
    always_ff @(posedge clock) begin
        if (reset) begin
            outstanding <= '0;
        end else begin
            case ({req_fire, mem_rsp_valid})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Number of in-flight responses that belong to a superseded path.  A
    // redirect replaces it with whatever will still be outstanding after
    // this cycle, which also makes back-to-back redirects recompute it.
    always_ff @(posedge clock) begin
        if (reset) begin
            discard <= '0;
        end else if (redirect) begin
            discard <= outstanding - CNT_W'(mem_rsp_valid);
        end else if (mem_rsp_valid && (state == FQ_DRAIN)) begin
            discard <= discard - CNT_W'(1);
        end
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (redirect),
        .push      (rsp_push),
        .push_data ({mem_rsp_data, rsp_pc}),
        .pop       (inst_pop),
        .pop_data  (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign inst_valid = !fifo_empty;
    assign inst       = fifo_head[ENTRY_W-1:XLEN];
    assign inst_pc    = fifo_head[XLEN-1:0];

    // Memory only answers requests it has accepted.
    assert property (@(posedge clock) disable iff (reset)
        mem_rsp_valid |-> (outstanding != '0));

    // The credit rule keeps a slot free for every response that gets pushed.
    assert property (@(posedge clock) disable iff (reset)
        rsp_push |-> !fifo_full);

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue.
// A behavioural instruction memory answers accepted requests in order one
// cycle later (or holds them while mem_hold is set).  Every accepted request
// pushes its expected {pc, data} onto a scoreboard, which is cleared on
// redirect and reset and compared against each instruction decode consumes.
module tb_ifetch_queue;

    localparam int          XLEN   = 32;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h8000_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic        inst_ready;
        logic        mem_req_ready;
        logic        exp_req_valid;
        logic [31:0] exp_req_addr;
        logic        exp_inst_valid;
        logic [31:0] exp_inst_pc;
    } vec_t;

    logic        clock;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    logic        rst_hold;
    logic        mem_hold;
    int          n_checks;
    int          n_fail;
    int          req_count;
    exp_t        sb[$];
    logic [31:0] mem_pend[$];
    exp_t        sb_head;
    vec_t        vecs[6];

    ifetch_queue #(
        .XLEN  (XLEN),
        .RESET (RST_PC),
        .DEPTH (DEPTH)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst          (inst),
        .inst_pc       (inst_pc)
    );

    // Free-running clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Instruction word the memory holds at a given address.
    function automatic logic [31:0] mem_data(input logic [31:0] addr);
        return {addr[23:0], addr[31:24]} ^ 32'h5A5A_1234;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Advance to just after the next rising edge, where inputs change.
    task automatic tick();
        @(posedge clock);
        #1;
        reset = rst_hold;
    endtask

    task automatic apply_reset();
        rst_hold = 1'b1;
        tick();
        @(negedge clock);
        check_output("rst_req_valid", 32'(mem_req_valid), 32'd0);
        tick();
        @(negedge clock);
        check_output("rst_inst_valid", 32'(inst_valid), 32'd0);
        check_output("rst_req_valid2", 32'(mem_req_valid), 32'd0);
        rst_hold = 1'b0;
    endtask

    task automatic apply_stimulus(input vec_t v);
        inst_ready    = v.inst_ready;
        mem_req_ready = v.mem_req_ready;
    endtask

    // Run cycles until decode sees a valid head, bounded by max_cycles.
    task automatic wait_inst(input int max_cycles, input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < max_cycles && !found; i++) begin
            tick();
            @(negedge clock);
            if (inst_valid) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("[TB] FAIL %s: inst_valid got 0 after %0d cycles, expected 1", name, max_cycles);
        end
    endtask

    // Behavioural memory: present the oldest accepted request, in order.
    always @(posedge clock) begin
        #2;
        if (!reset && !mem_hold && mem_pend.size() > 0) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = mem_data(mem_pend[0]);
        end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = '0;
        end
    end

    // Mid-cycle observer: scoreboard compare on pops, record handshakes.
    always @(negedge clock) begin
        if (reset) begin
            sb.delete();
            mem_pend.delete();
        end else begin
            if (inst_valid && inst_ready && !redirect) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL sb_pop: got pc %h, expected no instruction", inst_pc);
                end else begin
                    sb_head = sb.pop_front();
                    check_output("sb_pc", inst_pc, sb_head.pc);
                    check_output("sb_inst", inst, sb_head.data);
                end
            end
            if (redirect) sb.delete();
            if (mem_req_valid && mem_req_ready) begin
                mem_pend.push_back(mem_req_addr);
                sb.push_back('{pc: mem_req_addr, data: mem_data(mem_req_addr)});
                req_count++;
            end
            if (mem_rsp_valid && mem_pend.size() > 0) begin
                void'(mem_pend.pop_front());
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not reach the end");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int n0;
        n_checks      = 0;
        n_fail        = 0;
        req_count     = 0;
        rst_hold      = 1'b1;
        reset         = 1'b1;
        redirect      = 1'b0;
        redirect_pc   = '0;
        mem_req_ready = 1'b0;
        inst_ready    = 1'b0;
        mem_hold      = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;

        vecs[0] = '{1'b1, 1'b1, 1'b1, 32'h8000_0000, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 32'h8000_0004, 1'b0, 32'h0};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 32'h8000_0008, 1'b1, 32'h8000_0000};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h8000_000C, 1'b1, 32'h8000_0004};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 32'h8000_0010, 1'b1, 32'h8000_0008};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 32'h8000_0014, 1'b1, 32'h8000_000C};

        $display("[TB] streaming fetch from reset vector");
        inst_ready    = 1'b1;
        mem_req_ready = 1'b1;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            tick();
            apply_stimulus(vecs[i]);
            @(negedge clock);
            check_output($sformatf("v%0d_req_valid", i), 32'(mem_req_valid), 32'(vecs[i].exp_req_valid));
            check_output($sformatf("v%0d_req_addr", i), mem_req_addr, vecs[i].exp_req_addr);
            check_output($sformatf("v%0d_inst_valid", i), 32'(inst_valid), 32'(vecs[i].exp_inst_valid));
            if (vecs[i].exp_inst_valid) begin
                check_output($sformatf("v%0d_inst_pc", i), inst_pc, vecs[i].exp_inst_pc);
            end
        end

        $display("[TB] credit limit with decode stalled");
        inst_ready    = 1'b0;
        mem_req_ready = 1'b1;
        mem_hold      = 1'b0;
        apply_reset();
        n0 = req_count;
        repeat (10) begin tick(); @(negedge clock); end
        check_output("credit_reqs", 32'(req_count - n0), 32'd4);
        check_output("credit_block", 32'(mem_req_valid), 32'd0);
        tick();
        inst_ready = 1'b1;
        @(negedge clock);
        check_output("credit_pop_valid", 32'(inst_valid), 32'd1);
        tick();
        inst_ready = 1'b0;
        @(negedge clock);
        check_output("credit_refill", 32'(mem_req_valid), 32'd1);
        repeat (4) begin tick(); @(negedge clock); end
        check_output("credit_reqs2", 32'(req_count - n0), 32'd5);
        check_output("credit_block2", 32'(mem_req_valid), 32'd0);

        $display("[TB] redirect with two fetches in flight");
        mem_hold      = 1'b1;
        mem_req_ready = 1'b0;
        inst_ready    = 1'b1;
        apply_reset();
        tick(); redirect = 1'b1; redirect_pc = 32'h10; @(negedge clock);
        tick(); redirect = 1'b0; mem_req_ready = 1'b1; @(negedge clock);
        check_output("t3_addr0", mem_req_addr, 32'h10);
        tick(); @(negedge clock);
        check_output("t3_addr1", mem_req_addr, 32'h14);
        tick(); mem_req_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h103; @(negedge clock);
        check_output("t3_redirect_noreq", 32'(mem_req_valid), 32'd0);
        tick(); redirect = 1'b0; mem_req_ready = 1'b1; mem_hold = 1'b0; @(negedge clock);
        check_output("t3_addr_new", mem_req_addr, 32'h100);
        wait_inst(16, "t3_wait");
        check_output("t3_inst_pc", inst_pc, 32'h100);
        check_output("t3_inst", inst, mem_data(32'h100));

        $display("[TB] redirect with response and pop in the same cycle");
        mem_hold      = 1'b1;
        inst_ready    = 1'b0;
        mem_req_ready = 1'b1;
        apply_reset();
        repeat (4) begin tick(); @(negedge clock); end
        tick(); mem_req_ready = 1'b0; mem_hold = 1'b0; @(negedge clock);
        tick(); redirect = 1'b1; redirect_pc = 32'h200; inst_ready = 1'b1; @(negedge clock);
        check_output("t4_pre_valid", 32'(inst_valid), 32'd1);
        check_output("t4_redirect_noreq", 32'(mem_req_valid), 32'd0);
        tick(); redirect = 1'b0; mem_req_ready = 1'b1; @(negedge clock);
        check_output("t4_flushed", 32'(inst_valid), 32'd0);
        check_output("t4_addr_new", mem_req_addr, 32'h200);
        wait_inst(16, "t4_wait");
        check_output("t4_inst_pc", inst_pc, 32'h200);
        check_output("t4_inst", inst, mem_data(32'h200));

        $display("[TB] address wrap at top of memory");
        mem_hold      = 1'b0;
        mem_req_ready = 1'b0;
        inst_ready    = 1'b1;
        apply_reset();
        tick(); redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; @(negedge clock);
        tick(); redirect = 1'b0; mem_req_ready = 1'b1; @(negedge clock);
        check_output("wrap_addr0", mem_req_addr, 32'hFFFF_FFFC);
        tick(); @(negedge clock);
        check_output("wrap_addr1", mem_req_addr, 32'h0000_0000);
        tick(); @(negedge clock);
        check_output("wrap_valid0", 32'(inst_valid), 32'd1);
        check_output("wrap_pc0", inst_pc, 32'hFFFF_FFFC);
        tick(); @(negedge clock);
        check_output("wrap_pc1", inst_pc, 32'h0000_0000);

        $display("[TB] back-to-back redirects");
        mem_hold      = 1'b1;
        mem_req_ready = 1'b1;
        inst_ready    = 1'b1;
        apply_reset();
        repeat (2) begin tick(); @(negedge clock); end
        tick(); mem_req_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h300; @(negedge clock);
        tick(); redirect_pc = 32'h400; @(negedge clock);
        tick(); redirect = 1'b0; mem_hold = 1'b0; mem_req_ready = 1'b1; @(negedge clock);
        check_output("b2b_addr", mem_req_addr, 32'h400);
        wait_inst(16, "b2b_wait");
        check_output("b2b_inst_pc", inst_pc, 32'h400);
        check_output("b2b_inst", inst, mem_data(32'h400));

        $display("[TB] reset while busy");
        mem_hold      = 1'b1;
        inst_ready    = 1'b0;
        mem_req_ready = 1'b1;
        apply_reset();
        repeat (4) begin tick(); @(negedge clock); end
        tick(); mem_req_ready = 1'b0; mem_hold = 1'b0; @(negedge clock);
        repeat (2) begin tick(); @(negedge clock); end
        tick(); mem_hold = 1'b1; @(negedge clock);
        check_output("t6_busy_valid", 32'(inst_valid), 32'd1);
        rst_hold = 1'b1;
        tick(); @(negedge clock);
        check_output("t6_rst_req_valid", 32'(mem_req_valid), 32'd0);
        tick(); @(negedge clock);
        check_output("t6_rst_inst_valid", 32'(inst_valid), 32'd0);
        check_output("t6_rst_req_valid2", 32'(mem_req_valid), 32'd0);
        rst_hold = 1'b0;
        tick(); mem_hold = 1'b0; inst_ready = 1'b1; mem_req_ready = 1'b1; @(negedge clock);
        check_output("t6_req_valid", 32'(mem_req_valid), 32'd1);
        check_output("t6_req_addr", mem_req_addr, RST_PC);
        wait_inst(16, "t6_wait");
        check_output("t6_inst_pc", inst_pc, RST_PC);
        repeat (4) begin tick(); @(negedge clock); end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
